// File: rtl/uart_block_tx.sv
// uart_block_tx: buffered UART transmitter that sends a block of bytes from an internal RAM
//   clk, rst          : single clock, synchronous active-high reset
//   wr_en/addr/data   : byte writes into the block buffer (rejected while busy or out of range)
//   send, send_len    : start request and byte count (0 or oversize means BLOCK_SIZE)
//   busy, done        : busy from accepted send until done; done pulses once per block
//   wr_err            : one-cycle pulse after a rejected write
//   txd               : serial line, 8N1, idle high
//   Define UART_BLOCK_TX_HDR_EN to prefix each block with a header byte holding the length.
module uart_block_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int BLOCK_SIZE   = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       send,
  input  logic [7:0] send_len,
  output logic       busy,
  output logic       done,
  output logic       wr_err,
  output logic       txd
);
  localparam int AW = BLOCK_SIZE > 1 ? $clog2(BLOCK_SIZE) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [8:0] BS = 9'(BLOCK_SIZE);
`ifdef UART_BLOCK_TX_HDR_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] idx_q, idx_d, len_q, len_d;
  logic hdr_q, hdr_d, busy_q, busy_d, done_q, done_d, wr_err_q, wr_err_d, txd_q, txd_d;
  logic [7:0] mem [2**AW];
  logic [7:0] ram_q;
  logic accept, we, tick, last_byte;
  logic [7:0] eff_len, cur_byte;
  always_comb begin
    accept = send && !busy_q;
    we = wr_en && !busy_q && ({1'b0, wr_addr} < BS);
    eff_len = (send_len == 8'd0 || {1'b0, send_len} > BS) ? BS[7:0] : send_len;
    tick = cnt_q == LAST;
    cur_byte = hdr_q ? len_q : ram_q;
    last_byte = !hdr_q && ({1'b0, idx_q} + 9'd1 >= {1'b0, len_q});
    state_d = state_q;
    cnt_d = (state_q inside {START, DATA, STOP} && !tick) ? cnt_q + CW'(1) : '0;
    bit_d = bit_q;
    idx_d = idx_q;
    len_d = len_q;
    hdr_d = hdr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wr_err_d = wr_en && !we;
    txd_d = 1'b1;
    case (state_q)
      // busy is already low in DONE, so a send there starts the next block directly
      IDLE, DONE: begin
        state_d = accept ? LOAD : IDLE;
        if (accept) begin
          busy_d = 1'b1;
          idx_d = 8'd0;
          len_d = eff_len;
          hdr_d = HDR_EN;
        end
      end
      LOAD: state_d = START;
      START: begin
        txd_d = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        txd_d = cur_byte[bit_q];
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        state_d = last_byte ? DONE : LOAD;
        done_d = last_byte;
        busy_d = !last_byte;
        idx_d = (last_byte || hdr_q) ? idx_q : idx_q + 8'd1;
        hdr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      hdr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_err_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      len_q <= len_d;
      hdr_q <= hdr_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wr_err_q <= wr_err_d;
      txd_q <= txd_d;
    end
  end
  // Buffer RAM: one write port, registered read, never reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr[AW-1:0]] <= wr_data;
    if (state_q == LOAD) ram_q <= mem[idx_q[AW-1:0]];
  end
  assign busy = busy_q;
  assign done = done_q;
  assign wr_err = wr_err_q;
  assign txd = txd_q;
endmodule

// File: tb/tb_uart_block_tx.sv
// tb_uart_block_tx: directed self-checking bench for uart_block_tx with CLKS_PER_BIT=4, BLOCK_SIZE=128
module tb_uart_block_tx;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, send = 1'b0;
  logic [7:0] wr_addr = '0, wr_data = '0, send_len = '0;
  logic busy, done, wr_err, txd;
  logic [7:0] model [128];
  int total = 0, passed = 0;
`ifdef UART_BLOCK_TX_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  uart_block_tx #(.CLKS_PER_BIT(4), .BLOCK_SIZE(128)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .send(send), .send_len(send_len), .busy(busy), .done(done), .wr_err(wr_err), .txd(txd)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  // Sends a block and checks every frame; byte i starts 2+41*i cycles after the send edge.
  // inj > 0 issues a rejected write to address 5 plus a send at that cycle of the block.
  task automatic run_block(input logic [7:0] len, input int n, input int inj, input string tag);
    int nb, dones, off, bi;
    logic [9:0] fr;
    logic [7:0] eb;
    nb = n + HDR;
    dones = 0;
    fr = '0;
    send = 1'b1;
    send_len = len;
    step();
    send = 1'b0;
    wr_en = 1'b0;
    chk({tag, " busy_rise"}, busy, 1);
    for (int k = 1; k <= 41 * nb + 2; k++) begin
      step();
      if (k == inj) begin
        wr_en = 1'b1;
        wr_addr = 8'd5;
        wr_data = 8'hFF;
        send = 1'b1;
        send_len = 8'd3;
      end
      if (k == inj + 1) begin
        wr_en = 1'b0;
        send = 1'b0;
        chk({tag, " busy_wr_err"}, wr_err, 1);
      end
      if (done) dones++;
      if (k == 1) chk({tag, " txd_pre_start"}, txd, 1);
      if (k == 2) chk({tag, " txd_first_low"}, txd, 0);
      off = (k - 2) % 41;
      bi = (k - 2) / 41;
      if (k >= 2 && bi < nb && off % 4 == 2 && off <= 38) begin
        fr[off / 4] = txd;
        if (off == 38) begin
          eb = (HDR == 1 && bi == 0) ? 8'(n) : model[bi - HDR];
          chk($sformatf("%s frame%0d", tag, bi), {22'd0, fr}, {22'd0, 1'b1, eb, 1'b0});
        end
      end
      if (k == 41 * nb - 1) chk({tag, " busy_before_done"}, {busy, done}, 2'b10);
      if (k == 41 * nb) chk({tag, " done_busy_fall"}, {busy, done}, 2'b01);
    end
    chk({tag, " done_count"}, dones, 1);
  endtask
  initial begin
    int cnt;
    repeat (3) step();
    chk("reset_state", {txd, busy, done, wr_err}, 4'b1000);
    rst = 1'b0;
    step();
    wr(8'd0, 8'hA5);
    model[0] = 8'hA5;
    chk("wr_ok_no_err", wr_err, 0);
    run_block(8'd1, 1, -1, "single_a5");
    wr_en = 1'b1;
    wr_addr = 8'd0;
    wr_data = 8'h3C;
    model[0] = 8'h3C;
    run_block(8'd1, 1, -1, "wr_with_send");
    for (int i = 0; i < 128; i++) begin
      wr(8'(i), 8'(i));
      model[i] = 8'(i);
    end
    run_block(8'd0, 128, 100, "full_len0");
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy || done || !txd) cnt++;
    end
    chk("no_second_block", cnt, 0);
    wr(8'd130, 8'h77);
    chk("oob_wr_err", wr_err, 1);
    step();
    chk("oob_wr_err_pulse", wr_err, 0);
    run_block(8'd3, 3, -1, "after_oob");
    run_block(8'd200, 128, -1, "clamp_200");
    send = 1'b1;
    send_len = 8'd5;
    step();
    send = 1'b0;
    repeat (2 + 3 * 41 + 12) step();
    chk("busy_mid_byte3", busy, 1);
    rst = 1'b1;
    step();
    chk("abort_state", {txd, busy, done}, 3'b100);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy || done || !txd) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    run_block(8'd2, 2, -1, "after_abort");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_block_tx.md
UART_BLOCK_TX -- requirements
Module: uart_block_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter BLOCK_SIZE, default 128, meaning buffer depth in bytes (max 255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  input  1  buffer write strobe.
REQ-006 SHALL have port wr_addr  input  8  buffer write address.
REQ-007 SHALL have port wr_data  input  8  buffer write byte.
REQ-008 SHALL have port send  input  1  one-cycle request to transmit the block.
REQ-009 SHALL have port send_len  input  8  number of bytes to transmit, sampled with send.
REQ-010 SHALL have port busy  output  1  high from accepted send until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse after the last stop bit.
REQ-012 SHALL have port wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-013 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-014 SHALL store wr_data at wr_addr on wr_en when busy=0 and wr_addr<BLOCK_SIZE; else drop it and pulse wr_err next cycle.
REQ-015 SHALL accept send only when busy=0; send during busy SHALL be ignored without side effects.
REQ-016 SHALL latch effective length L=send_len, except send_len=0 or >BLOCK_SIZE gives L=BLOCK_SIZE.
REQ-017 SHALL implement states IDLE, LOAD, START, DATA, STOP, DONE.
REQ-018 IDLE->LOAD on accepted send. LOAD reads buffer[idx] for 1 cycle, then goes to START.
REQ-019 START drives txd=0 for CLKS_PER_BIT cycles, then goes to DATA.
REQ-020 DATA drives 8 bits LSB first, CLKS_PER_BIT cycles each, then goes to STOP.
REQ-021 STOP drives txd=1 for CLKS_PER_BIT cycles. It then goes to LOAD with idx+1 if more bytes remain, else to DONE.
REQ-022 DONE pulses done=1 for 1 cycle, clears busy in the same cycle, and returns to IDLE.
REQ-023 busy SHALL rise the cycle after send is accepted.
REQ-024 txd SHALL first go low 2 cycles after the send edge.
REQ-025 Consecutive bytes SHALL be separated by exactly 1 LOAD cycle, so byte period = 10*CLKS_PER_BIT+1.
REQ-026 Bytes SHALL be sent from address 0 up to L-1; idx SHALL be 8 bits wide and SHALL NOT wrap within a block.
REQ-027 Simultaneous wr_en and send in IDLE SHALL both take effect; the written byte is visible to the first LOAD.
REQ-028 Buffer SHALL be a single write-port, registered-read RAM (inferable as BRAM/LUTRAM).

Reset
REQ-029 On rst: state=IDLE, txd=1, busy=0, done=0, wr_err=0, counters=0, all taking effect the cycle after rst is sampled high.
REQ-030 rst asserted mid-byte SHALL abort the frame at once, without a stop bit or done pulse.
REQ-031 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro UART_BLOCK_TX_HDR_EN: when defined, SHALL send one header byte equal to L (8-bit; BLOCK_SIZE when clamped) before buffer byte 0. The header uses the same framing, making total bytes L+1.
REQ-033 Without UART_BLOCK_TX_HDR_EN, SHALL send exactly L buffer bytes with no header.

Verification (CLKS_PER_BIT=4, BLOCK_SIZE=128)
REQ-034 Write 0xA5 @0, send, send_len=1 -> txd low at +2 cycles, bits 1,0,1,0,0,1,0,1, stop; done at 41 cycles after send edge; busy falls with done.
REQ-035 Fill 0..127 with addr value, send_len=0 -> 128 bytes 0x00..0x7F in order; done once.
REQ-036 Mid-block: wr_en and send asserted while busy -> wr_err pulse, buffer unchanged, no second block.
REQ-037 rst during DATA of byte 3 -> txd=1 the next cycle, busy=0, no done; a new send works normally.
REQ-038 With UART_BLOCK_TX_HDR_EN, send_len=200 -> header 0x80, then 128 bytes.
REQ-039 wr_addr=130, wr_en in IDLE -> wr_err pulse and no store.
